// File: rtl/lorenz_pkg.sv
// Shared constants and state encoding for the Lorenz integrator sequencers (7.20 signed fixed point).
// Also imported by the VGA plotter sequencer.
package lorenz_pkg;

  localparam int WIDTH = 27;
  localparam int FRAC  = 20;

  localparam logic signed [WIDTH-1:0] ONE       = 27'sd1 <<< FRAC;
  localparam logic signed [WIDTH-1:0] LIMIT_DEF = 27'sd62 <<< FRAC;

  // Number of cycles the integrators are held in load.
  localparam int LOAD_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_STEP    = 3'd3,
    S_CAPTURE = 3'd4,
    S_HANDOFF = 3'd5,
    S_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/lorenz_step_tick.sv
// Step-rate divider: free counter of DIV_BITS bits, cleared while disabled.
// tick_o is combinational and high in the last count of each 2**DIV_BITS-cycle period.
module lorenz_step_tick #(
  parameter int DIV_BITS = 5
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [DIV_BITS-1:0] cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (!reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == {DIV_BITS{1'b1}});

endmodule

// File: rtl/lorenz_step_controller.sv
// Sequences load / step / capture for the x,y,z integrators and hands each vector downstream.
// Steps every 2**DIV_BITS+3 clocks with ready high; a pending sample stalls stepping losslessly.
module lorenz_step_controller #(
  parameter int                                       WIDTH    = lorenz_pkg::WIDTH,
  parameter int                                       DIV_BITS = 5,
  parameter int                                       CNT_BITS = 16,
  parameter logic signed [lorenz_pkg::WIDTH-1:0]      LIMIT    = lorenz_pkg::LIMIT_DEF
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CNT_BITS-1:0]        step_limit,
  input  logic signed [WIDTH-1:0]    x0,
  input  logic signed [WIDTH-1:0]    y0,
  input  logic signed [WIDTH-1:0]    z0,
  input  logic signed [WIDTH-1:0]    x_in,
  input  logic signed [WIDTH-1:0]    y_in,
  input  logic signed [WIDTH-1:0]    z_in,
  output logic signed [WIDTH-1:0]    init_x,
  output logic signed [WIDTH-1:0]    init_y,
  output logic signed [WIDTH-1:0]    init_z,
  output logic                       int_reset_n,
  output logic                       int_en,
  output logic signed [WIDTH-1:0]    smp_x,
  output logic signed [WIDTH-1:0]    smp_y,
  output logic signed [WIDTH-1:0]    smp_z,
  output logic                       smp_valid,
  input  logic                       smp_ready,
  output logic                       busy,
  output logic                       ovf,
  output logic [CNT_BITS-1:0]        step_count
);

  import lorenz_pkg::*;

  state_t                  state_q;
  logic                    load_q;
  logic signed [WIDTH-1:0] init_x_q, init_y_q, init_z_q;
  logic signed [WIDTH-1:0] smp_x_q, smp_y_q, smp_z_q;
  logic                    int_reset_n_q, int_en_q, smp_valid_q, busy_q, ovf_q;
  logic [CNT_BITS-1:0]     step_count_q;

  logic                    tick;
  logic                    xfer;
  logic                    run_end;
  logic                    ovf_d;
  logic [CNT_BITS-1:0]     step_count_d;

  lorenz_step_tick #(
    .DIV_BITS (DIV_BITS)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clr_i    (state_q != S_RUN),
    .en_i     (state_q == S_RUN),
    .tick_o   (tick)
  );

  function automatic logic over_limit(input logic signed [WIDTH-1:0] v);
    return (v >= LIMIT) || (v <= -LIMIT);
  endfunction

  assign ovf_d        = over_limit(x_in) || over_limit(y_in) || over_limit(z_in);
  // Saturate rather than wrap so a long free run still reports a meaningful count.
  assign step_count_d = (&step_count_q) ? step_count_q : step_count_q + 1'b1;
  assign xfer         = smp_valid_q && smp_ready;
  assign run_end      = ovf_q || ((step_limit != '0) && (step_count_q == step_limit));

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      load_q        <= 1'b0;
      init_x_q      <= '0;
      init_y_q      <= '0;
      init_z_q      <= '0;
      smp_x_q       <= '0;
      smp_y_q       <= '0;
      smp_z_q       <= '0;
      int_reset_n_q <= 1'b1;
      int_en_q      <= 1'b0;
      smp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      ovf_q         <= 1'b0;
      step_count_q  <= '0;
    end else if (abort) begin
      // step_count, ovf and the last sample are left for inspection.
      state_q       <= S_IDLE;
      int_en_q      <= 1'b0;
      int_reset_n_q <= 1'b1;
      smp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q       <= S_LOAD;
            load_q        <= 1'b0;
            init_x_q      <= x0;
            init_y_q      <= y0;
            init_z_q      <= z0;
            step_count_q  <= '0;
            ovf_q         <= 1'b0;
            int_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        S_LOAD: begin
          load_q <= 1'b1;
          if (load_q) begin
            state_q       <= S_RUN;
            int_reset_n_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (tick) begin
            state_q  <= S_STEP;
            int_en_q <= 1'b1;
          end
        end
        S_STEP: begin
          state_q      <= S_CAPTURE;
          int_en_q     <= 1'b0;
          step_count_q <= step_count_d;
        end
        S_CAPTURE: begin
          state_q     <= S_HANDOFF;
          smp_x_q     <= x_in;
          smp_y_q     <= y_in;
          smp_z_q     <= z_in;
          smp_valid_q <= 1'b1;
          if (ovf_d) begin
            ovf_q <= 1'b1;
          end
        end
        S_HANDOFF: begin
          if (xfer) begin
            smp_valid_q <= 1'b0;
            if (run_end) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign init_x      = init_x_q;
  assign init_y      = init_y_q;
  assign init_z      = init_z_q;
  assign int_reset_n = int_reset_n_q;
  assign int_en      = int_en_q;
  assign smp_x       = smp_x_q;
  assign smp_y       = smp_y_q;
  assign smp_z       = smp_z_q;
  assign smp_valid   = smp_valid_q;
  assign busy        = busy_q;
  assign ovf         = ovf_q;
  assign step_count  = step_count_q;

endmodule

// File: tb/tb_lorenz_step_controller.sv
// Randomized scoreboard bench: a toy linear integrator feeds the controller, expected vectors are x0+k*dx.
module tb_lorenz_step_controller;

  import lorenz_pkg::*;

  localparam int W      = 27;
  localparam int DB     = 5;
  localparam int CB     = 16;
  localparam int PERIOD = 1 << DB;
  localparam int ONE_I  = 1 << 20;
  localparam int LIM_I  = 62 << 20;

  logic                 CLOCK_50, reset, start, abort, smp_ready;
  logic [CB-1:0]        step_limit;
  logic signed [W-1:0]  x0, y0, z0, x_in, y_in, z_in;
  logic signed [W-1:0]  init_x, init_y, init_z, smp_x, smp_y, smp_z;
  logic                 int_reset_n, int_en, smp_valid, busy, ovf;
  logic [CB-1:0]        step_count;
  logic signed [W-1:0]  dx, dy, dz;

  typedef struct packed {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
  } vec_t;

  vec_t exp_q[$];
  int   n_tests, n_fail;
  int   cyc, xfer_cnt, rst_low_cnt, rise_cyc;
  int   en_cyc[$];

  lorenz_step_controller dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .step_limit  (step_limit),
    .x0          (x0),
    .y0          (y0),
    .z0          (z0),
    .x_in        (x_in),
    .y_in        (y_in),
    .z_in        (z_in),
    .init_x      (init_x),
    .init_y      (init_y),
    .init_z      (init_z),
    .int_reset_n (int_reset_n),
    .int_en      (int_en),
    .smp_x       (smp_x),
    .smp_y       (smp_y),
    .smp_z       (smp_z),
    .smp_valid   (smp_valid),
    .smp_ready   (smp_ready),
    .busy        (busy),
    .ovf         (ovf),
    .step_count  (step_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Toy integrator: loads on int_reset_n low, adds a constant delta per step enable.
  always @(posedge CLOCK_50) begin
    if (!int_reset_n) begin
      x_in <= init_x; y_in <= init_y; z_in <= init_z;
    end else if (int_en) begin
      x_in <= x_in + dx; y_in <= y_in + dy; z_in <= z_in + dz;
    end
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic vec_t mkvec(input int k);
    vec_t v;
    v.x = W'(x0 + k * dx);
    v.y = W'(y0 + k * dy);
    v.z = W'(z0 + k * dz);
    return v;
  endfunction

  function automatic logic mag_over(input logic signed [W-1:0] v);
    int iv;
    iv = int'(v);
    return (iv >= LIM_I) || (iv <= -LIM_I);
  endfunction

  function automatic int steps_to_ovf();
    vec_t v;
    for (int k = 1; k < 4096; k++) begin
      v = mkvec(k);
      if (mag_over(v.x) || mag_over(v.y) || mag_over(v.z)) return k;
    end
    return 4096;
  endfunction

  function automatic logic signed [W-1:0] rnd_fix(input int range);
    return W'(int'($urandom_range(0, 2 * range)) - range);
  endfunction

  // Monitor / scoreboard: samples on the falling edge, away from DUT updates.
  initial begin
    logic prev_irn, pend;
    vec_t held, e;
    cyc = 0; xfer_cnt = 0; rst_low_cnt = 0; rise_cyc = 0;
    prev_irn = 1'b1; pend = 1'b0; held = '0;
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (int_reset_n === 1'b0) rst_low_cnt++;
      if (int_reset_n === 1'b1 && !prev_irn) rise_cyc = cyc;
      prev_irn = (int_reset_n !== 1'b0);
      if (int_en === 1'b1) begin
        en_cyc.push_back(cyc);
        check("no_step_while_pending", smp_valid, 0);
      end
      if (pend) begin
        check("hold_valid", smp_valid, 1);
        check("hold_data", ({smp_x, smp_y, smp_z} == held), 1);
      end
      if (smp_valid === 1'b1 && smp_ready && !abort && reset) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_xfer_queue_len", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("smp_x", smp_x, e.x);
          check("smp_y", smp_y, e.y);
          check("smp_z", smp_z, e.z);
        end
      end
      pend = (smp_valid === 1'b1) && !smp_ready && !abort && reset;
      held = {smp_x, smp_y, smp_z};
    end
  end

  initial begin
    #1600000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (busy !== 1'b0) check({name, "_timeout_busy"}, busy, 0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (smp_valid !== 1'b1 && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (smp_valid !== 1'b1) check({name, "_timeout_valid"}, smp_valid, 1);
  endtask

  task automatic push_run(input int n);
    for (int k = 1; k <= n; k++) exp_q.push_back(mkvec(k));
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_smp_valid"}, smp_valid, 0);
    check({p, "_int_en"}, int_en, 0);
    check({p, "_int_reset_n"}, int_reset_n, 1);
    check({p, "_ovf"}, ovf, 0);
    check({p, "_step_count"}, step_count, 0);
    check({p, "_smp_x"}, smp_x, 0);
    check({p, "_init_x"}, init_x, 0);
  endtask

  task automatic rand_small();
    x0 = rnd_fix(8 * ONE_I); y0 = rnd_fix(8 * ONE_I); z0 = rnd_fix(8 * ONE_I);
    dx = rnd_fix(ONE_I / 2); dy = rnd_fix(ONE_I / 2); dz = rnd_fix(ONE_I / 2);
  endtask

  initial begin
    int rl0, e0, e1, x0c, lim, kovf;
    logic signed [W-1:0] ax, big, dbig;
    n_tests = 0; n_fail = 0;
    CLOCK_50 = 1'b0; reset = 1'b0; start = 1'b0; abort = 1'b0; smp_ready = 1'b0;
    step_limit = '0; x0 = '0; y0 = '0; z0 = '0; dx = '0; dy = '0; dz = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b1;
    tick();

    // Load and stepping: first run is the 1.0/1.0/1.0 single step, second a random 3-step run.
    for (int it = 0; it < 2; it++) begin
      lim = (it == 0) ? 1 : 3;
      if (it == 0) begin
        x0 = ONE; y0 = ONE; z0 = ONE;
        dx = rnd_fix(ONE_I / 2); dy = rnd_fix(ONE_I / 2); dz = rnd_fix(ONE_I / 2);
      end else begin
        rand_small();
      end
      step_limit = CB'(lim); smp_ready = 1'b1;
      rl0 = rst_low_cnt; e0 = en_cyc.size(); x0c = xfer_cnt;
      push_run(lim);
      pulse_start();
      check("busy_after_start", busy, 1);
      wait_done(lim * 50 + 20, "run");
      check("load_low_cycles", rst_low_cnt - rl0, 2);
      check("int_en_pulses", en_cyc.size() - e0, lim);
      if (en_cyc.size() > e0) check("first_step_delay", en_cyc[e0] - rise_cyc, PERIOD);
      for (int k = 1; k < lim; k++)
        if (en_cyc.size() > e0 + k) check("step_latency", en_cyc[e0 + k] - en_cyc[e0 + k - 1], PERIOD + 3);
      check("run_xfers", xfer_cnt - x0c, lim);
      check("run_step_count", step_count, lim);
      check("run_ovf", ovf, 0);
      check("run_init_x", init_x, x0);
      check("run_sb_empty", exp_q.size(), 0);
    end

    // Back-pressure: consumer stalls 100 cycles after the first vector.
    rand_small();
    step_limit = CB'(4); smp_ready = 1'b0;
    x0c = xfer_cnt;
    push_run(4);
    pulse_start();
    wait_valid(100, "bp");
    e1 = en_cyc.size();
    repeat (100) tick();
    check("bp_no_step", en_cyc.size() - e1, 0);
    check("bp_valid_held", smp_valid, 1);
    check("bp_no_xfer", xfer_cnt - x0c, 0);
    smp_ready = 1'b1;
    wait_done(400, "bp");
    check("bp_xfers", xfer_cnt - x0c, 4);
    check("bp_step_count", step_count, 4);
    check("bp_sb_empty", exp_q.size(), 0);

    // Overflow in free-run: once on +x, once on -y.
    for (int it = 0; it < 2; it++) begin
      big  = W'(int'($urandom_range(0, 4 * ONE_I)));
      dbig = W'(ONE_I / 2 + int'($urandom_range(0, ONE_I / 2)));
      x0 = rnd_fix(4 * ONE_I); y0 = rnd_fix(4 * ONE_I); z0 = rnd_fix(4 * ONE_I);
      dx = rnd_fix(ONE_I / 16); dy = rnd_fix(ONE_I / 16); dz = rnd_fix(ONE_I / 16);
      if (it == 0) begin
        x0 = big; dx = dbig;
      end else begin
        y0 = -big; dy = -dbig;
      end
      kovf = steps_to_ovf();
      step_limit = '0; smp_ready = 1'b1;
      x0c = xfer_cnt;
      push_run(kovf);
      pulse_start();
      wait_done(kovf * 40 + 100, "ovf");
      check("ovf_set", ovf, 1);
      check("ovf_step_count", step_count, kovf);
      check("ovf_xfers", xfer_cnt - x0c, kovf);
      check("ovf_sb_empty", exp_q.size(), 0);
    end
    rand_small();
    step_limit = CB'(1);
    push_run(1);
    pulse_start();
    check("ovf_cleared_on_start", ovf, 0);
    wait_done(100, "post_ovf");
    check("post_ovf_flag", ovf, 0);
    check("post_ovf_step_count", step_count, 1);

    // Abort beats a same-cycle transfer.
    rand_small();
    step_limit = CB'(3); smp_ready = 1'b0;
    push_run(3);
    pulse_start();
    wait_valid(100, "abort");
    tick();
    x0c = xfer_cnt;
    abort = 1'b1; smp_ready = 1'b1;
    tick();
    abort = 1'b0; smp_ready = 1'b0;
    @(negedge CLOCK_50);
    check("abort_no_xfer", xfer_cnt - x0c, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", smp_valid, 0);
    check("abort_int_en", int_en, 0);
    check("abort_int_reset_n", int_reset_n, 1);
    check("abort_step_count_kept", step_count, 1);
    exp_q.delete();
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge CLOCK_50);
    check("start_abort_busy", busy, 0);

    // Reset while a sample is pending in handoff.
    rand_small();
    step_limit = CB'(2); smp_ready = 1'b0;
    push_run(2);
    tick();
    pulse_start();
    wait_valid(100, "rst_mid");
    tick();
    reset = 1'b0;
    tick();
    @(negedge CLOCK_50);
    check_reset_vals("rst_mid");
    exp_q.delete();
    reset = 1'b1;
    tick();
    rand_small();
    smp_ready = 1'b1; x0c = xfer_cnt;
    push_run(2);
    pulse_start();
    wait_done(200, "after_rst");
    check("after_rst_step_count", step_count, 2);
    check("after_rst_xfers", xfer_cnt - x0c, 2);
    check("after_rst_sb_empty", exp_q.size(), 0);

    // Start while busy is ignored.
    rand_small();
    step_limit = CB'(3); smp_ready = 1'b1;
    x0c = xfer_cnt;
    push_run(3);
    pulse_start();
    ax = x0;
    repeat (10) tick();
    x0 = x0 + ONE; y0 = y0 - ONE; z0 = z0 + ONE;
    pulse_start();
    check("busy_start_init_x", init_x, ax);
    wait_done(300, "busy_start");
    check("busy_start_step_count", step_count, 3);
    check("busy_start_xfers", xfer_cnt - x0c, 3);
    check("busy_start_init_kept", init_x, ax);
    check("busy_start_sb_empty", exp_q.size(), 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
